bitmap_encoder: RTL

//   Inverse of the 2-to-4 line decoder: converts an N-bit request bitmap into a stream of binary indices.

---
 rtl/bitmap_enc_pkg.sv | 16 +
 rtl/bitmap_encoder_if.sv | 39 +++
 rtl/prio_index_enc.sv | 28 ++
 rtl/bitmap_encoder.sv | 70 +++++++
 4 files changed

// File: rtl/bitmap_enc_pkg.sv
// Shared types and helpers for the bitmap-to-index stream encoder.
// Scan order is selected by BITMAP_ENC_MSB_FIRST_EN (see prio_index_enc).
package bitmap_enc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam state_e RST_STATE = IDLE;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bitmap_encoder_if.sv
// Valid/ready bundle: bitmap in, index/last stream out.
// master drives requests and out_ready; slave is the encoder.
interface bitmap_encoder_if
  import bitmap_enc_pkg::*;
#(
  parameter int N = 4
) ();

  localparam int W = idx_w(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_vec;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_last;

  modport master (
    output in_valid,
    output in_vec,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_idx,
    input  out_last
  );

  modport slave (
    input  in_valid,
    input  in_vec,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_idx,
    output out_last
  );

endinterface

// File: rtl/prio_index_enc.sv
// Combinational N-to-W priority encoder with single-bit flag.
// BITMAP_ENC_MSB_FIRST_EN picks the highest set bit, else the lowest.
module prio_index_enc #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         one_hot_o
);

  always_comb begin
    idx_o = '0;
`ifdef BITMAP_ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (vec_i[i]) idx_o = W'(i);
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = W'(i);
    end
`endif
  end

  assign one_hot_o = (vec_i != '0) &&
                     ((vec_i & (vec_i - 1'b1)) == '0);

endmodule

// File: rtl/bitmap_encoder.sv
// Bitmap to index stream: one beat per set bit, last marks the final one.
// Scan order: lowest first, or highest first with BITMAP_ENC_MSB_FIRST_EN.
module bitmap_encoder
  import bitmap_enc_pkg::*;
#(
  parameter  int N = 4,
  localparam int W = idx_w(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  bitmap_encoder_if.slave  bus,
  output logic             busy
);

  state_e         state_q, state_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   clr;
  logic [W-1:0]   idx;
  logic           one_hot;
  logic           beat;
  logic           acc;
  logic           emit;

  prio_index_enc #(
    .N (N),
    .W (W)
  ) u_enc (
    .vec_i     (pending_q),
    .idx_o     (idx),
    .one_hot_o (one_hot)
  );

  assign emit          = (state_q == EMIT);
  assign bus.out_valid = emit;
  assign bus.out_idx   = idx;
  assign bus.out_last  = one_hot;
  assign busy          = emit;

  // Ready on the last beat lets the next vector load with no bubble.
  assign bus.in_ready = !emit ||
                        (bus.out_ready && one_hot);

  assign beat = emit && bus.out_ready;
  assign acc  = bus.in_valid && bus.in_ready;
  assign clr  = {{(N-1){1'b0}}, 1'b1} << idx;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    if (beat) begin
      pending_d = pending_q & ~clr;
      if (one_hot) state_d = IDLE;
    end
    if (acc) begin
      pending_d = bus.in_vec;
      state_d   = (bus.in_vec != '0) ? EMIT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RST_STATE;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
    end
  end

endmodule
